// File: rtl/nav_pkg.sv
// Shared definitions for the grid-cursor navigator: button bit map, FSM states,
// and the wrap-around step helper.
package nav_pkg;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } nav_state_e;

  // One cell forward (inc=1) or back (inc=0) on a 0..grid-1 ring.
  function automatic logic [3:0] step_wrap(input logic [3:0] v, input logic inc,
                                           input int grid);
    logic [3:0] last;
    last = 4'(grid - 1);
    if (inc) return (v == last) ? 4'd0 : v + 4'd1;
    else     return (v == 4'd0) ? last : v - 4'd1;
  endfunction

endpackage

// File: rtl/nav_repeat_timer.sv
// Auto-repeat counter shared by the initial-delay and repeat-rate phases;
// restarts from zero on clear or on reaching the terminal count.
module nav_repeat_timer #(
  parameter int DELAY = 3_000_000,
  parameter int RATE  = 600_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rate_phase,
  output logic tc
);

  localparam int MAXC = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [CW-1:0] cnt_q, cnt_d, limit;

  always_comb begin
    limit = rate_phase ? CW'(RATE - 1) : CW'(DELAY - 1);
    tc    = (cnt_q == limit);
    cnt_d = (clr || tc) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cursor_nav.sv
// 9x9 cursor navigator: priority-encoded direction presses, wrap-around steps,
// hold-to-auto-repeat, and a select strobe delayed one cycle from the center press.
module cursor_nav
  import nav_pkg::*;
#(
  parameter int GRID         = 9,
  parameter int REPEAT_DELAY = 3_000_000,
  parameter int REPEAT_RATE  = 600_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_level,
  input  logic [4:0] btn_pulse,
  input  logic       lock,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       move_pulse,
  output logic       sel_pulse
);

  nav_state_e state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic       move_q, move_d, sel_q, sel_d;

  logic       has_dir, dir_held, do_step, tmr_clr, tmr_tc;
  logic [1:0] act_dir, step_dir;

  nav_repeat_timer #(
    .DELAY (REPEAT_DELAY),
    .RATE  (REPEAT_RATE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (tmr_clr),
    .rate_phase (state_q == ST_REPEAT),
    .tc         (tmr_tc)
  );

  // Lower bit index = higher priority.
  always_comb begin
    has_dir = |btn_pulse[3:0];
    act_dir = 2'(BTN_RIGHT);
    if (btn_pulse[BTN_LEFT]) act_dir = 2'(BTN_LEFT);
    if (btn_pulse[BTN_DOWN]) act_dir = 2'(BTN_DOWN);
    if (btn_pulse[BTN_UP])   act_dir = 2'(BTN_UP);
    dir_held = btn_level[{1'b0, dir_q}];
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    row_d    = row_q;
    col_d    = col_q;
    move_d   = 1'b0;
    sel_d    = btn_pulse[BTN_CENTER] && !lock;
    do_step  = 1'b0;
    step_dir = dir_q;
    tmr_clr  = 1'b1;

    if (lock) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (has_dir) begin
            do_step  = 1'b1;
            step_dir = act_dir;
            dir_d    = act_dir;
            state_d  = ST_DELAY;
          end
        end
        default: begin
          // A released direction lets any fresh press through, as if from idle.
          if (has_dir && (act_dir < dir_q || !dir_held)) begin
            do_step  = 1'b1;
            step_dir = act_dir;
            dir_d    = act_dir;
            state_d  = ST_DELAY;
          end else if (!dir_held) begin
            state_d = ST_IDLE;
          end else begin
            tmr_clr = 1'b0;
            if (tmr_tc) begin
              do_step = 1'b1;
              state_d = ST_REPEAT;
            end
          end
        end
      endcase
    end

    if (do_step) begin
      move_d = 1'b1;
      case (step_dir)
        2'(BTN_UP):   row_d = step_wrap(row_q, 1'b0, GRID);
        2'(BTN_DOWN): row_d = step_wrap(row_q, 1'b1, GRID);
        2'(BTN_LEFT): col_d = step_wrap(col_q, 1'b0, GRID);
        default:      col_d = step_wrap(col_q, 1'b1, GRID);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 2'd0;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      move_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      row_q   <= row_d;
      col_q   <= col_d;
      move_q  <= move_d;
      sel_q   <= sel_d;
    end
  end

  assign row        = row_q;
  assign col        = col_q;
  assign move_pulse = move_q;
  assign sel_pulse  = sel_q;

endmodule

// File: tb/tb_cursor_nav.sv
// Randomized + directed bench for cursor_nav with a time-scheduled reference
// model feeding a scoreboard of expected move/select events.
module tb_cursor_nav;

  localparam int GRID = 9;
  localparam int RD   = 8;
  localparam int RR   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn_level = '0;
  logic [4:0] btn_pulse = '0;
  logic       lock = 1'b0;
  logic [3:0] row, col;
  logic       move_pulse, sel_pulse;

  cursor_nav #(.GRID(GRID), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .lock       (lock),
    .row        (row),
    .col        (col),
    .move_pulse (move_pulse),
    .sel_pulse  (sel_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    bit mv;
    bit sl;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   chk_en = 0;

  // Reference model: absolute cycle scheduling of the next repeat.
  int m_row = 0, m_col = 0, m_held = -1, m_next = 0, m_cyc = 0;
  logic [4:0] prev_lvl = '0;

  function automatic int wrap(input int v);
    return (v + GRID) % GRID;
  endfunction

  task automatic model(input logic [4:0] lvl, input logic [4:0] pls, input bit lk, input bit r);
    int p, sdir;
    bit step, sel;
    exp_t e;
    m_cyc++;
    step = 0;
    sel  = 0;
    sdir = 0;
    if (r) begin
      m_row = 0; m_col = 0; m_held = -1;
    end else if (lk) begin
      m_held = -1;
    end else begin
      p = -1;
      for (int i = 3; i >= 0; i--) if (pls[i]) p = i;
      if (p >= 0 && (m_held < 0 || p < m_held || !lvl[m_held])) begin
        step = 1; sdir = p; m_held = p; m_next = m_cyc + RD;
      end else if (m_held >= 0 && !lvl[m_held]) begin
        m_held = -1;
      end else if (m_held >= 0 && m_cyc == m_next) begin
        step = 1; sdir = m_held; m_next = m_cyc + RR;
      end
      sel = pls[4];
      if (step) begin
        case (sdir)
          0: m_row = wrap(m_row - 1);
          1: m_row = wrap(m_row + 1);
          2: m_col = wrap(m_col - 1);
          default: m_col = wrap(m_col + 1);
        endcase
      end
      if (step || sel) begin
        e.row = m_row; e.col = m_col; e.mv = step; e.sl = sel;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_pos();
    n_total++;
    if (row == 4'(m_row) && col == 4'(m_col)) n_pass++;
    else $display("FAIL position @%0t: got (%0d,%0d), want (%0d,%0d)", $time, row, col, m_row, m_col);
  endtask

  task automatic tick(input logic [4:0] lvl, input bit lk, input bit r);
    @(negedge clk);
    if (chk_en) check_pos();
    btn_pulse = lvl & ~prev_lvl;
    btn_level = lvl;
    prev_lvl  = lvl;
    lock      = lk;
    rst       = r;
    model(lvl, btn_pulse, lk, r);
  endtask

  task automatic tap(input logic [4:0] lvl);
    tick(lvl, 0, 0);
    tick(5'b0, 0, 0);
  endtask

  // Monitor: every DUT strobe must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en && (move_pulse || sel_pulse)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe @%0t: got move=%0b sel=%0b at (%0d,%0d), want none",
                 $time, move_pulse, sel_pulse, row, col);
      end else begin
        e = exp_q.pop_front();
        if (row == 4'(e.row) && col == 4'(e.col) && move_pulse == e.mv && sel_pulse == e.sl)
          n_pass++;
        else
          $display("FAIL scoreboard @%0t: got (%0d,%0d) move=%0b sel=%0b, want (%0d,%0d) move=%0b sel=%0b",
                   $time, row, col, move_pulse, sel_pulse, e.row, e.col, e.mv, e.sl);
      end
    end
  end

  initial begin
    logic [4:0] lvl;
    bit lk;
    tick(5'b0, 0, 1);
    tick(5'b0, 0, 1);
    chk_en = 1;
    tick(5'b0, 0, 0);

    // Single right tap, then quiet.
    tap(5'b01000);
    repeat (12) tick(5'b0, 0, 0);
    // Wrap: up from row 0, right from col 8.
    tap(5'b00001);
    repeat (7) tap(5'b01000);
    tap(5'b01000);
    // Back to row 0, then hold down 20 cycles after the press.
    tap(5'b00010);
    repeat (20) tick(5'b00010, 0, 0);
    repeat (6) tick(5'b0, 0, 0);
    // Hold left, down arrives at cycle 5 and takes over.
    repeat (5) tick(5'b00100, 0, 0);
    repeat (14) tick(5'b00110, 0, 0);
    repeat (4) tick(5'b0, 0, 0);
    // Reach (3,3), then center + right together.
    tick(5'b0, 0, 1);
    repeat (3) tap(5'b00010);
    repeat (3) tap(5'b01000);
    tick(5'b11000, 0, 0);
    repeat (3) tick(5'b0, 0, 0);
    // Lock mid-repeat with center taps, release lock while still holding.
    repeat (15) tick(5'b01000, 0, 0);
    repeat (3) begin
      tick(5'b11000, 1, 0);
      tick(5'b01000, 1, 0);
    end
    repeat (12) tick(5'b01000, 0, 0);
    tick(5'b0, 0, 0);
    // Reset mid-delay while down is held.
    tap(5'b00010);
    repeat (3) tick(5'b00010, 0, 0);
    tick(5'b00010, 0, 1);
    repeat (10) tick(5'b00010, 0, 0);
    tick(5'b0, 0, 0);

    // Random phase.
    lvl = '0;
    lk  = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 15) == 0) lvl[b] = ~lvl[b];
      if ($urandom_range(0, 59) == 0) lk = ~lk;
      tick(lvl, lk, $urandom_range(0, 399) == 0);
    end
    repeat (4) tick(5'b0, 0, 0);

    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_strobes: got %0d events still pending, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
